issue_buffer: RTL
=================

Name: issue_buffer

Overview:
- Dual-ported circular instruction queue between decode and the issue/EXE register stage.
- Accepts up to two decoded instructions per cycle and presents up to two head entries per cycle, first-word-fall-through.
- Withholds the second head entry when it has a RAW dependency on the first.
- Supports a downstream stall (DCache) and a branch flush.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 4.
- DATA_W, 160, width of the opaque instruction payload (packed decode bundle).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid1  input  1  decode slot 1 carries an instruction.
- in_valid2  input  1  decode slot 2 carries an instruction (program order after slot 1).
- in_data1  input  DATA_W  slot 1 payload.
- in_data2  input  DATA_W  slot 2 payload.
- in_meta1  input  16  slot 1 hazard fields: [15:11] rd, [10] rf_we, [9:5] raddr1, [4:0] raddr2.
- in_meta2  input  16  slot 2 hazard fields, same layout.
- in_ready  output  1  buffer can accept two instructions this cycle.
- flush  input  1  branch-mispredict flush.
- stall  input  1  downstream stall; no pop this cycle.
- o_valid1  output  1  head entry valid for issue.
- o_valid2  output  1  head+1 entry valid for issue.
- o_data1  output  DATA_W  head payload.
- o_data2  output  DATA_W  head+1 payload.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- State: storage array of DEPTH entries (payload + meta), rd_ptr, wr_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), and count register.
- Reset (rst=1 at posedge): rd_ptr=0, wr_ptr=0, count=0. Storage contents are don't-care.
  - Outputs after reset: o_valid1=0, o_valid2=0, o_data1=0, o_data2=0, in_ready=1.
- in_ready = (DEPTH - count) >= 2.
  - Combinational from registered count only; does not depend on a same-cycle pop.
- Push occurs when in_ready=1 and at least one in_validN is asserted.
  - Number pushed = in_valid1 + in_valid2.
  - Entries are compacted: the first valid slot goes to wr_ptr, the second to wr_ptr+1.
  - in_valid2 alone writes slot 2 at wr_ptr.
  - Pushes with in_ready=0 are ignored; decode must hold its data.
- Fall-through latency: an entry written at edge t is visible on o_data at t+1. There is no same-cycle bypass.
- o_valid1 = (count >= 1) & ~flush.
- o_valid2 = (count >= 2) & ~flush & ~raw.
  - raw = head.rf_we & (head.rd != 0) & ((head.rd == next.raddr1) | (head.rd == next.raddr2)).
  - rd=0 never creates a hazard.
- o_dataN = stored payload when o_validN=1, else 0.
- Pop occurs when stall=0 and flush=0.
  - Number popped = o_valid1 + o_valid2; rd_ptr advances by that amount.
  - The downstream stage always consumes every presented valid entry when not stalled.
  - With stall=1: no pop; outputs hold their values (same head).
- Update rule: count_next = count + pushed - popped.
  - Simultaneous push and pop is legal, including at count = DEPTH-2.
- Flush has priority over push, pop and stall.
  - At the edge: rd_ptr=0, wr_ptr=0, count=0, and same-cycle pushes are discarded.
  - During the flush cycle, o_valid1 and o_valid2 are 0 combinationally.
- rst has priority over flush.
- Order invariant: the issue order equals the push order across pointer wrap.
- Assertions (bench):
  - count never exceeds DEPTH.
  - No pop ever occurs from an empty entry.

Test Plan:
- Push A (meta rd=3, we=1, ra=1/2) and B (rd=4, ra=5/6) after reset, stall=0.
  - Next cycle: o_valid1=o_valid2=1, o_data1=A, o_data2=B, count=2.
  - Following cycle: count=0, o_valid1=0.
- RAW pair: A rd=5 we=1; B raddr1=5.
  - Cycle 1: o_valid1=1, o_valid2=0, A popped.
  - Cycle 2: o_data1=B, o_valid1=1, count=0 after.
- No false hazards:
  - A rd=0 we=1 with B raddr1=0: o_valid2=1.
  - A rd=5 we=0 with B raddr2=5: o_valid2=1.
- Fill with stall=1 (DEPTH=16): push 7 pairs, then one single.
  - count=15, in_ready=0.
  - A further push of two is ignored: count stays 15.
  - Release stall: 2 pop per cycle (independent metas), in_ready=1 when count<=14, drains in order.
- Flush at count=6 with simultaneous push of 2.
  - Same cycle: o_valid1=o_valid2=0.
  - Next cycle: count=0, in_ready=1, o_data=0.
  - A push after that appears at the head one cycle later.
- Wrap and compaction: stream 40 instructions, mixing in_valid2-only pushes and random stall.
  - Issued sequence equals pushed sequence exactly.
  - Assert rst mid-stream: next cycle count=0, outputs 0.

Source files
------------

// File: rtl/issue_buffer.sv
// issue_buffer: dual-ported circular instruction queue sitting between decode
// and the issue/EXE register stage. Up to two decoded instructions enter per
// cycle and up to two head entries are presented per cycle, first-word-fall-
// through. The second head entry is withheld when it reads a register that
// the first head entry writes.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid1/2          decode slot valids (slot 2 follows slot 1 in order)
//   in_data1/2           opaque instruction payloads
//   in_meta1/2           hazard fields {rd[4:0], rf_we, raddr1[4:0], raddr2[4:0]}
//   in_ready             room for two instructions (from registered count)
//   flush                branch-mispredict flush, empties the queue
//   stall                downstream stall, nothing is popped
//   o_valid1/2, o_data1/2  head and head+1 entries presented for issue
//   count                current occupancy
module issue_buffer #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 160
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid1,
  input  logic                     in_valid2,
  input  logic [DATA_W-1:0]        in_data1,
  input  logic [DATA_W-1:0]        in_data2,
  input  logic [15:0]              in_meta1,
  input  logic [15:0]              in_meta2,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic                     stall,
  output logic                     o_valid1,
  output logic                     o_valid2,
  output logic [DATA_W-1:0]        o_data1,
  output logic [DATA_W-1:0]        o_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [15:0]       meta_mem_r [DEPTH];
  logic [AW-1:0]     rd_ptr_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [CW-1:0]     count_r;

  logic [AW-1:0]     next_ptr_s;
  logic [AW-1:0]     wr2_ptr_s;
  logic              raw_s;
  logic              push_en_s;
  logic [1:0]        push_n_s;
  logic [1:0]        pop_n_s;

  // RAW check between the head entry and the entry behind it; x0 never hazards.
  function automatic logic raw_hazard(input logic [15:0] head_meta,
                                      input logic [15:0] next_meta);
    logic [4:0] rd;
    rd = head_meta[15:11];
    return head_meta[10] & (rd != 5'd0) &
           ((rd == next_meta[9:5]) | (rd == next_meta[4:0]));
  endfunction

  assign count = count_r;

  // Presentation, hazard gating and push/pop amounts for this cycle.
  always_comb begin
    in_ready   = (count_r <= CW'(DEPTH - 2));
    next_ptr_s = rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
    raw_s      = raw_hazard(meta_mem_r[rd_ptr_r], meta_mem_r[next_ptr_s]);
    o_valid1   = (count_r != {CW{1'b0}}) & ~flush;
    o_valid2   = (count_r >= CW'(2)) & ~flush & ~raw_s;
    if (o_valid1) begin
      o_data1 = data_mem_r[rd_ptr_r];
    end else begin
      o_data1 = {DATA_W{1'b0}};
    end
    if (o_valid2) begin
      o_data2 = data_mem_r[next_ptr_s];
    end else begin
      o_data2 = {DATA_W{1'b0}};
    end
    push_en_s = in_ready & (in_valid1 | in_valid2);
    if (push_en_s) begin
      push_n_s = {1'b0, in_valid1} + {1'b0, in_valid2};
    end else begin
      push_n_s = 2'd0;
    end
    // flush already forces both valids low, so it needs no extra gating here
    if (stall) begin
      pop_n_s = 2'd0;
    end else begin
      pop_n_s = {1'b0, o_valid1} + {1'b0, o_valid2};
    end
    // compaction: slot 2 lands right after slot 1, or at wr_ptr if alone
    wr2_ptr_s = wr_ptr_r + {{(AW-1){1'b0}}, in_valid1};
  end

  // Storage writes; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (push_en_s & ~flush & ~rst) begin
      if (in_valid1) begin
        data_mem_r[wr_ptr_r] <= in_data1;
        meta_mem_r[wr_ptr_r] <= in_meta1;
      end
      if (in_valid2) begin
        data_mem_r[wr2_ptr_s] <= in_data2;
        meta_mem_r[wr2_ptr_s] <= in_meta2;
      end
    end
  end

  // Pointer and occupancy update; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      rd_ptr_r <= rd_ptr_r + AW'(pop_n_s);
      wr_ptr_r <= wr_ptr_r + AW'(push_n_s);
      count_r  <= count_r + CW'(push_n_s) - CW'(pop_n_s);
    end
  end

endmodule
